prog_calc_engine: RTL

- Parametrised programmable accumulator. Load mode appends {opCode, value} instructions to an internal cache of DEPTH entries.
- Execute mode runs one cached instruction per enabled cycle against a DATA_W-bit result register. The program loops back to a programmable start index.
- Successor to the fixed 10-bit / 32-entry lab calculator. Adds generic widths and depth, an enable handshake, a SUB opcode with borrow, a full-load error, and program-counter and occupancy visibility for the lab top level.

---
 rtl/prog_calc_engine.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/prog_calc_engine.sv
// Programmable accumulator: load mode appends {opcode, value} to an instruction cache,
// execute mode runs one cached instruction per enabled cycle and loops to a start index.
module prog_calc_engine #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned VAL_W  = 4,
  parameter int unsigned DEPTH  = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              mode,
  input  logic [2:0]        opCode,
  input  logic [VAL_W-1:0]  value,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] prevResult,
  output logic              cacheFull,
  output logic [AW:0]       count,
  output logic [AW-1:0]     pc,
  output logic              invalidOp,
  output logic              overflow
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = 2 * DATA_W + 1;

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_ACC     = 3'd1,
    OP_MAC     = 3'd2,
    OP_SUB     = 3'd3,
    OP_POPC    = 3'd4,
    OP_NOT     = 3'd5,
    OP_SETLOOP = 3'd6,
    OP_INV     = 3'd7
  } op_e;

  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [AW-1:0]     loop_q, loop_d;
  logic              full_q, full_d;
  logic              inv_q, inv_d;
  logic              ovf_q, ovf_d;
  logic              wr_en;
  logic [FW-1:0]     wide;

  logic [2:0]        mem_op  [DEPTH];
  logic [VAL_W-1:0]  mem_val [DEPTH];

  op_e               cur_op;
  logic [VAL_W-1:0]  cur_v;

  assign cur_op = op_e'(mem_op[pc_q]);
  assign cur_v  = mem_val[pc_q];

  // Next-state logic for load/execute; SETLOOP feeds loop_d so a wrap on the same cycle sees it.
  always_comb begin
    result_d = result_q;
    prev_d   = prev_q;
    count_d  = count_q;
    pc_d     = pc_q;
    loop_d   = loop_q;
    full_d   = full_q;
    inv_d    = 1'b0;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    wide     = '0;
    if (en) begin
      if (!mode) begin
        if (opCode == OP_INV || full_q) begin
          inv_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
          full_d  = (count_d == CW'(DEPTH));
        end
      end else if (count_q != '0) begin
        prev_d = result_q;
        ovf_d  = 1'b0;
        case (cur_op)
          OP_ADD: begin
            wide     = FW'(result_q) + FW'(cur_v);
            result_d = wide[DATA_W-1:0];
            ovf_d    = |wide[FW-1:DATA_W];
          end
          OP_ACC: begin
            wide     = FW'(result_q) + FW'(prev_q) + FW'(cur_v);
            result_d = wide[DATA_W-1:0];
            ovf_d    = |wide[FW-1:DATA_W];
          end
          OP_MAC: begin
            wide     = FW'(result_q) * FW'(prev_q) + FW'(cur_v);
            result_d = wide[DATA_W-1:0];
            ovf_d    = |wide[FW-1:DATA_W];
          end
          OP_SUB: begin
            result_d = result_q - DATA_W'(cur_v);
            ovf_d    = FW'(cur_v) > FW'(result_q);
          end
          OP_POPC:    result_d = DATA_W'($countones(result_q));
          OP_NOT:     result_d = ~result_q;
          OP_SETLOOP: loop_d   = AW'(cur_v);
          default: ;
        endcase
        if (CW'(pc_q) == count_q - CW'(1)) begin
          pc_d = (CW'(loop_d) < count_q) ? loop_d : '0;
        end else begin
          pc_d = pc_q + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      result_q <= '0;
      prev_q   <= '0;
      count_q  <= '0;
      pc_q     <= '0;
      loop_q   <= '0;
      full_q   <= 1'b0;
      inv_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      prev_q   <= prev_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
      loop_q   <= loop_d;
      full_q   <= full_d;
      inv_q    <= inv_d;
      ovf_q    <= ovf_d;
    end
  end

  // Instruction cache; contents are not reset.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem_op[count_q[AW-1:0]]  <= opCode;
      mem_val[count_q[AW-1:0]] <= value;
    end
  end

  assign result     = result_q;
  assign prevResult = prev_q;
  assign count      = count_q;
  assign pc         = pc_q;
  assign cacheFull  = full_q;
  assign invalidOp  = inv_q;
  assign overflow   = ovf_q;

endmodule
